// File: rtl/hilo_muldiv_unit.sv
// HI/LO owning multiply/divide unit: single-cycle multiply-class ops and a
// restoring divider that keeps Busy high until the quotient/remainder land.
module hilo_muldiv_unit #(
    parameter int unsigned DIV_STEPS = 32
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] HIRegOutput,
    output logic [31:0] LORegOutput
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned CNT_W  = $clog2(DIV_STEPS + 1);

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        FINISH
    } state_t;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MADD  = 3'b100,
        OP_MSUB  = 3'b101,
        OP_MTHI  = 3'b110,
        OP_MTLO  = 3'b111
    } op_t;

    state_t              state;
    state_t              stateNext;
    op_t                 opCode;

    logic [DATA_W-1:0]   hiReg;
    logic [DATA_W-1:0]   loReg;
    logic                busyReg;
    logic                doneReg;

    logic [DATA_W-1:0]   divisor;
    logic [DATA_W-1:0]   quoAcc;
    logic [DATA_W-1:0]   remAcc;
    logic [DATA_W-1:0]   dividendRaw;
    logic [CNT_W-1:0]    divCount;
    logic                quoNeg;
    logic                remNeg;
    logic                divZero;

    logic                isDivOp;
    logic                signedDiv;
    logic [PROD_W-1:0]   prodSigned;
    logic [PROD_W-1:0]   prodUnsigned;
    logic [PROD_W-1:0]   accSum;
    logic [PROD_W-1:0]   accDiff;
    logic [DATA_W-1:0]   absA;
    logic [DATA_W-1:0]   absB;
    logic [DATA_W:0]     shifted;
    logic                trialOk;
    logic [DATA_W-1:0]   remNext;
    logic [DATA_W-1:0]   quoNext;
    logic [DATA_W-1:0]   quoFinal;
    logic [DATA_W-1:0]   remFinal;
    logic                lastStep;

    assign opCode = op_t'(Op);

    // State register
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (Start && isDivOp) begin
                    stateNext = DIVIDE;
                end
            end
            DIVIDE: begin
                if (lastStep) begin
                    stateNext = FINISH;
                end
            end
            FINISH: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Operand decode, products and one restoring division step
    always_comb begin
        isDivOp      = (opCode == OP_DIV) || (opCode == OP_DIVU);
        signedDiv    = (opCode == OP_DIV);
        prodSigned   = PROD_W'($signed(A)) * PROD_W'($signed(B));
        prodUnsigned = PROD_W'(A) * PROD_W'(B);
        accSum       = {hiReg, loReg} + prodSigned;
        accDiff      = {hiReg, loReg} - prodSigned;
        absA         = (signedDiv && A[DATA_W-1]) ? DATA_W'(~A + DATA_W'(1)) : A;
        absB         = (signedDiv && B[DATA_W-1]) ? DATA_W'(~B + DATA_W'(1)) : B;

        shifted      = {remAcc, quoAcc[DATA_W-1]};
        trialOk      = (shifted >= {1'b0, divisor});
        remNext      = trialOk ? DATA_W'(shifted[DATA_W-1:0] - divisor)
                               : shifted[DATA_W-1:0];
        quoNext      = {quoAcc[DATA_W-2:0], trialOk};
        lastStep     = (divCount == CNT_W'(DIV_STEPS - 1));

        quoFinal     = quoNeg ? DATA_W'(~quoAcc + DATA_W'(1)) : quoAcc;
        remFinal     = remNeg ? DATA_W'(~remAcc + DATA_W'(1)) : remAcc;
    end

    // HI/LO, divider datapath and status registers
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            hiReg       <= '0;
            loReg       <= '0;
            busyReg     <= 1'b0;
            doneReg     <= 1'b0;
            divisor     <= '0;
            quoAcc      <= '0;
            remAcc      <= '0;
            dividendRaw <= '0;
            divCount    <= '0;
            quoNeg      <= 1'b0;
            remNeg      <= 1'b0;
            divZero     <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        doneReg <= !isDivOp;
                        case (opCode)
                            OP_MULT:  {hiReg, loReg} <= prodSigned;
                            OP_MULTU: {hiReg, loReg} <= prodUnsigned;
                            OP_MADD:  {hiReg, loReg} <= accSum;
                            OP_MSUB:  {hiReg, loReg} <= accDiff;
                            OP_MTHI:  hiReg <= A;
                            OP_MTLO:  loReg <= A;
                            OP_DIV, OP_DIVU: begin
                                divisor     <= absB;
                                quoAcc      <= absA;
                                remAcc      <= '0;
                                divCount    <= '0;
                                dividendRaw <= A;
                                divZero     <= (B == '0);
                                quoNeg      <= signedDiv && (A[DATA_W-1] ^ B[DATA_W-1]);
                                remNeg      <= signedDiv && A[DATA_W-1];
                                busyReg     <= 1'b1;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                DIVIDE: begin
                    remAcc   <= remNext;
                    quoAcc   <= quoNext;
                    divCount <= CNT_W'(divCount + CNT_W'(1));
                end
                FINISH: begin
                    // Divide by zero reports all-ones quotient and the raw dividend
                    if (divZero) begin
                        loReg <= '1;
                        hiReg <= dividendRaw;
                    end else begin
                        loReg <= quoFinal;
                        hiReg <= remFinal;
                    end
                    busyReg <= 1'b0;
                    doneReg <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign Busy        = busyReg;
    assign Done        = doneReg;
    assign HIRegOutput = hiReg;
    assign LORegOutput = loReg;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: a reference model pushes expected
// {HI,LO} on every issued op, and each Done pulse pops and compares.
module tb_hilo_muldiv_unit;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MSUB  = 3'b101;
    localparam logic [2:0] OP_MTHI  = 3'b110;
    localparam logic [2:0] OP_MTLO  = 3'b111;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic        Done;
    logic [31:0] HIRegOutput;
    logic [31:0] LORegOutput;

    int          checkCount;
    int          failCount;
    logic [31:0] mHi;
    logic [31:0] mLo;
    logic [63:0] expQ[$];

    hilo_muldiv_unit #(.DIV_STEPS(32)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .Op          (Op),
        .A           (A),
        .B           (B),
        .Busy        (Busy),
        .Done        (Done),
        .HIRegOutput (HIRegOutput),
        .LORegOutput (LORegOutput)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        if (obs !== exp) begin
            failCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: update architectural HI/LO and queue the expectation
    task automatic modelOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int          sq;
        int          sr;
        p = 64'(longint'($signed(a)) * longint'($signed(b)));
        case (op)
            OP_MULT:  {mHi, mLo} = p;
            OP_MULTU: {mHi, mLo} = {32'd0, a} * {32'd0, b};
            OP_MADD:  {mHi, mLo} = {mHi, mLo} + p;
            OP_MSUB:  {mHi, mLo} = {mHi, mLo} - p;
            OP_MTHI:  mHi = a;
            OP_MTLO:  mLo = a;
            default: begin
                if (b == 32'd0) begin
                    mLo = 32'hFFFF_FFFF;
                    mHi = a;
                end else if (op == OP_DIVU) begin
                    mLo = a / b;
                    mHi = a % b;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    mLo = 32'h8000_0000;
                    mHi = 32'd0;
                end else begin
                    sq  = $signed(a) / $signed(b);
                    sr  = $signed(a) % $signed(b);
                    mLo = 32'(sq);
                    mHi = 32'(sr);
                end
            end
        endcase
        expQ.push_back({mHi, mLo});
    endtask

    // Drive one Start pulse; returns 1 time unit after the accepting edge
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge Clk);
        Start = 1'b1;
        Op    = op;
        A     = a;
        B     = b;
        @(posedge Clk);
        #1;
        Start = 1'b0;
    endtask

    task automatic doOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        modelOp(op, a, b);
        issue(op, a, b);
    endtask

    // Bounded wait for Done, sampled on negedges; reports cycles waited
    task automatic waitDone(output int cycles);
        cycles = 0;
        while (cycles < 40) begin
            @(negedge Clk);
            cycles++;
            if (Done) break;
        end
        if (!Done) checkVal("done_timeout", 64'(Done), 64'd1);
    endtask

    // Scoreboard consumer
    always @(negedge Clk) begin
        if (Done) begin
            if (expQ.size() == 0) begin
                checkVal("unexpected_done", 64'(Done), 64'd0);
            end else begin
                checkVal("scoreboard_result", {HIRegOutput, LORegOutput}, expQ.pop_front());
            end
        end
    end

    initial begin
        logic [63:0] hold;
        logic        ok;
        int          cyc;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        checkCount = 0;
        failCount  = 0;
        mHi   = '0;
        mLo   = '0;
        Reset = 1'b0;
        Start = 1'b0;
        Op    = '0;
        A     = '0;
        B     = '0;

        repeat (3) @(posedge Clk);
        @(negedge Clk);
        checkVal("reset_hilo", {HIRegOutput, LORegOutput}, 64'd0);
        checkVal("reset_busy", 64'(Busy), 64'd0);
        checkVal("reset_done", 64'(Done), 64'd0);
        Reset = 1'b1;

        // MULT / MULTU back to back
        doOp(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
        checkVal("mult_hilo", {HIRegOutput, LORegOutput}, 64'hFFFF_FFFF_FFFF_FFFE);
        checkVal("mult_done", 64'(Done), 64'd1);
        checkVal("mult_busy", 64'(Busy), 64'd0);
        doOp(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
        checkVal("multu_hilo", {HIRegOutput, LORegOutput}, 64'h0000_0001_FFFF_FFFE);
        @(negedge Clk);
        @(negedge Clk);
        checkVal("done_single", 64'(Done), 64'd0);

        // Signed divide with exact latency and held HI/LO
        hold = {HIRegOutput, LORegOutput};
        doOp(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        ok = 1'b1;
        for (int i = 0; i < 33; i++) begin
            @(negedge Clk);
            ok &= Busy && !Done && ({HIRegOutput, LORegOutput} == hold);
        end
        checkVal("div_busy_window", 64'(ok), 64'd1);
        @(negedge Clk);
        checkVal("div_done", 64'(Done), 64'd1);
        checkVal("div_busy_clear", 64'(Busy), 64'd0);
        checkVal("div_hilo", {HIRegOutput, LORegOutput}, 64'hFFFF_FFFF_FFFF_FFFD);
        @(negedge Clk);
        checkVal("div_done_single", 64'(Done), 64'd0);

        // Divide by zero and signed overflow
        doOp(OP_DIVU, 32'h0000_0064, 32'h0000_0000);
        waitDone(cyc);
        checkVal("divz_latency", 64'(cyc), 64'd34);
        checkVal("divz_hilo", {HIRegOutput, LORegOutput}, 64'h0000_0064_FFFF_FFFF);
        doOp(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        waitDone(cyc);
        checkVal("div_ovf_hilo", {HIRegOutput, LORegOutput}, 64'h0000_0000_8000_0000);
        doOp(OP_DIV, 32'h8000_0000, 32'h0000_0000);
        waitDone(cyc);
        checkVal("divz_signed_hilo", {HIRegOutput, LORegOutput}, 64'h8000_0000_FFFF_FFFF);

        // Accumulate with carry/borrow across LO
        doOp(OP_MTHI, 32'h0000_0000, 32'h0);
        doOp(OP_MTLO, 32'hFFFF_FFFF, 32'h0);
        doOp(OP_MADD, 32'h1, 32'h1);
        checkVal("madd_hilo", {HIRegOutput, LORegOutput}, 64'h0000_0001_0000_0000);
        doOp(OP_MSUB, 32'h1, 32'h1);
        checkVal("msub_hilo", {HIRegOutput, LORegOutput}, 64'h0000_0000_FFFF_FFFF);

        // Start during Busy is dropped
        doOp(OP_DIVU, 32'd10, 32'd3);
        repeat (5) @(negedge Clk);
        issue(OP_MTLO, 32'h0000_1234, 32'h0);
        waitDone(cyc);
        checkVal("busy_ignore_hilo", {HIRegOutput, LORegOutput}, 64'h0000_0001_0000_0003);

        // Reset aborts an in-flight divide
        issue(OP_DIV, 32'd100, 32'd7);
        repeat (9) @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        mHi = '0;
        mLo = '0;
        checkVal("abort_hilo", {HIRegOutput, LORegOutput}, 64'd0);
        checkVal("abort_busy", 64'(Busy), 64'd0);
        checkVal("abort_done", 64'(Done), 64'd0);
        @(negedge Clk);
        Reset = 1'b1;
        ok = 1'b1;
        repeat (40) begin
            @(negedge Clk);
            ok &= !Done && !Busy;
        end
        checkVal("abort_no_done", 64'(ok), 64'd1);
        doOp(OP_MULT, 32'd3, 32'd4);
        checkVal("post_abort_mult", {HIRegOutput, LORegOutput}, 64'd12);

        // Random mix through the scoreboard
        for (int i = 0; i < 12; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = (i % 4 == 3) ? 32'd0 : 32'($urandom);
            if (i % 3 == 1) ra = 32'($signed(-($urandom_range(1, 1000))));
            doOp(rop, ra, rb);
            if (rop == OP_DIV || rop == OP_DIVU) waitDone(cyc);
        end

        repeat (3) @(negedge Clk);
        checkVal("scoreboard_drained", 64'(expQ.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
